// File: rtl/rf_wb_pkg.sv
// Shared widths, limits and types for the register-file write-back arbiter.
// All widths default to a 32 x 32 register file with 2-bit pending counters.
package rf_wb_pkg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  localparam int NREGS   = 1 << AW;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [AW-1:0] R0 = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grants from the valids and a
// pointer that only moves when both requesters compete.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       rr_ptr
);

  logic contested;

  assign contested = valid[0] & valid[1];

  // rr_ptr names the requester that wins the next contested cycle
  always_comb begin
    grant = 2'b00;
    if (contested) begin
      grant[0] = ~rr_ptr;
      grant[1] = rr_ptr;
    end else begin
      grant[0] = valid[0];
      grant[1] = valid[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= 1'b0;
    end else if (contested) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the ALU and load paths and
// tracks outstanding writes per register for read-after-write hazard checks.
module rf_wb_arbiter #(
  parameter int DW = rf_wb_pkg::DW,
  parameter int AW = rf_wb_pkg::AW,
  parameter int CW = rf_wb_pkg::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          resv_valid,
  input  logic [AW-1:0] resv_addr,
  output logic          resv_ready,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_wr,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  output logic          hazard1,
  output logic          hazard2
);

  import rf_wb_pkg::*;

  localparam int            NR       = 1 << AW;
  localparam logic [CW-1:0] CNT_FULL = CW'(CNT_MAX);
  localparam logic [AW-1:0] ZERO_REG = AW'(R0);

  logic [1:0]    grant;
  logic          rr_ptr;
  logic          xfer;
  wb_req_t       xfer_req;
  logic          resv_fire;
  logic [CW-1:0] cnt [NR];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .grant  (grant),
    .rr_ptr (rr_ptr)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = grant[0] | grant[1];

  always_comb begin
    xfer_req.addr = req0_addr;
    xfer_req.data = req0_data;
    if (grant[1]) begin
      xfer_req.addr = req1_addr;
      xfer_req.data = req1_data;
    end
  end

  // A full counter can still take a reservation when a write to the same
  // register retires in the same cycle, since the net count does not move.
  always_comb begin
    resv_ready = 1'b1;
    if (resv_addr != ZERO_REG && cnt[resv_addr] == CNT_FULL &&
        !(xfer && xfer_req.addr == resv_addr)) begin
      resv_ready = 1'b0;
    end
  end

  assign resv_fire = resv_valid & resv_ready & (resv_addr != ZERO_REG);

  // Writes to r0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wr <= 1'b0;
      rf_a3 <= '0;
      rf_wd <= '0;
    end else begin
      rf_wr <= xfer && (xfer_req.addr != ZERO_REG);
      if (xfer) begin
        rf_a3 <= xfer_req.addr;
        rf_wd <= xfer_req.data;
      end
    end
  end

  // Retiring a write on an empty counter is a protocol error; it saturates at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NR; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NR; r++) begin
        if (resv_fire && resv_addr == AW'(r) &&
            !(xfer && xfer_req.addr == AW'(r))) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (xfer && xfer_req.addr == AW'(r) &&
                     !(resv_fire && resv_addr == AW'(r))) begin
          if (cnt[r] != '0) begin
            cnt[r] <= cnt[r] - 1'b1;
          end
        end
      end
    end
  end

  assign hazard1 = (cnt[rd_a1] != '0);
  assign hazard2 = (cnt[rd_a2] != '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        resv_valid;
  logic [4:0]  resv_addr;
  logic        resv_ready;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_wr;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [4:0]  rd_a1;
  logic [4:0]  rd_a2;
  logic        hazard1;
  logic        hazard2;

  int compared;
  int mismatched;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .resv_valid (resv_valid),
    .resv_addr  (resv_addr),
    .resv_ready (resv_ready),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_wr      (rf_wr),
    .rf_a3      (rf_a3),
    .rf_wd      (rf_wd),
    .rd_a1      (rd_a1),
    .rd_a2      (rd_a2),
    .hazard1    (hazard1),
    .hazard2    (hazard2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAAAA_0001;
    rd_a1 = 5'd3; rd_a2 = 5'd3; resv_addr = 5'd3;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++; if (rf_wr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rf_wr: got %b expected 0", rf_wr); end
      compared++; if (rf_a3 !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_rf_a3: got %0d expected 0", rf_a3); end
      compared++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hazard: got %b%b expected 00", hazard1, hazard2); end
      compared++; if (resv_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_resv_ready: got %b expected 1", resv_ready); end
      compared++; if (req0_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_req0_ready: got %b expected 1", req0_ready); end
    end
    rst = 1'b1;
    step();
    compared++; if (rf_wr !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_rf_wr: got %b expected 1", rf_wr); end
    compared++; if (rf_a3 !== 5'd3) begin mismatched++; $display("[TB] FAIL post_reset_rf_a3: got %0d expected 3", rf_a3); end
    compared++; if (rf_wd !== 32'hAAAA_0001) begin mismatched++; $display("[TB] FAIL post_reset_rf_wd: got %h expected aaaa0001", rf_wd); end
    compared++; if (hazard1 !== 1'b0) begin mismatched++; $display("[TB] FAIL underflow_hazard: got %b expected 0", hazard1); end
    req0_valid = 1'b0;
    step();
    compared++; if (rf_wr !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_rf_wr: got %b expected 0", rf_wr); end
    compared++; if (rf_a3 !== 5'd3) begin mismatched++; $display("[TB] FAIL idle_rf_a3_hold: got %0d expected 3", rf_a3); end
  endtask

  task automatic test_contested();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h22;
    #1;
    compared++; if ({req1_ready, req0_ready} !== 2'b01) begin mismatched++; $display("[TB] FAIL contest_grant0: got %b%b expected 01", req1_ready, req0_ready); end
    step();
    compared++; if (rf_wr !== 1'b1 || rf_a3 !== 5'd5 || rf_wd !== 32'h11) begin mismatched++; $display("[TB] FAIL contest_first: got wr=%b a3=%0d wd=%h expected 1/5/11", rf_wr, rf_a3, rf_wd); end
    req0_valid = 1'b0;
    #1;
    compared++; if ({req1_ready, req0_ready} !== 2'b10) begin mismatched++; $display("[TB] FAIL contest_grant1: got %b%b expected 10", req1_ready, req0_ready); end
    step();
    compared++; if (rf_wr !== 1'b1 || rf_a3 !== 5'd6 || rf_wd !== 32'h22) begin mismatched++; $display("[TB] FAIL contest_second: got wr=%b a3=%0d wd=%h expected 1/6/22", rf_wr, rf_a3, rf_wd); end
    req1_valid = 1'b0;
  endtask

  task automatic test_rr_ptr();
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h33;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h44;
    #1;
    compared++; if ({req1_ready, req0_ready} !== 2'b10) begin mismatched++; $display("[TB] FAIL rr_ptr_favours_req1: got %b%b expected 10", req1_ready, req0_ready); end
    step();
    compared++; if (rf_a3 !== 5'd11 || rf_wd !== 32'h44) begin mismatched++; $display("[TB] FAIL rr_ptr_commit: got a3=%0d wd=%h expected 11/44", rf_a3, rf_wd); end
    req1_valid = 1'b0;
    step();
    compared++; if (rf_wr !== 1'b1 || rf_a3 !== 5'd10) begin mismatched++; $display("[TB] FAIL rr_ptr_req0_alone: got wr=%b a3=%0d expected 1/10", rf_wr, rf_a3); end
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'h55;
    req0_valid = 1'b1;
    #1;
    compared++; if ({req1_ready, req0_ready} !== 2'b01) begin mismatched++; $display("[TB] FAIL rr_ptr_back_to_req0: got %b%b expected 01", req1_ready, req0_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_scoreboard();
    resv_valid = 1'b1; resv_addr = 5'd7; rd_a1 = 5'd7;
    #1;
    compared++; if (hazard1 !== 1'b0 || resv_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL sb_initial: got hz=%b rr=%b expected 0/1", hazard1, resv_ready); end
    step();
    step();
    resv_valid = 1'b0;
    #1;
    compared++; if (hazard1 !== 1'b1) begin mismatched++; $display("[TB] FAIL sb_reserved: got %b expected 1", hazard1); end
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    step();
    req0_valid = 1'b0;
    #1;
    compared++; if (rf_wr !== 1'b1 || hazard1 !== 1'b1) begin mismatched++; $display("[TB] FAIL sb_first_commit: got wr=%b hz=%b expected 1/1", rf_wr, hazard1); end
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h78;
    step();
    req1_valid = 1'b0;
    #1;
    compared++; if (rf_wr !== 1'b1 || rf_wd !== 32'h78 || hazard1 !== 1'b0) begin mismatched++; $display("[TB] FAIL sb_second_commit: got wr=%b wd=%h hz=%b expected 1/78/0", rf_wr, rf_wd, hazard1); end
  endtask

  task automatic test_saturation();
    resv_valid = 1'b1; resv_addr = 5'd9; rd_a2 = 5'd9;
    step();
    step();
    #1;
    compared++; if (resv_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_two_ready: got %b expected 1", resv_ready); end
    step();
    #1;
    compared++; if (resv_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_full_ready: got %b expected 0", resv_ready); end
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    #1;
    compared++; if (resv_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_with_commit: got %b expected 1", resv_ready); end
    step();
    req1_valid = 1'b0;
    #1;
    compared++; if (rf_a3 !== 5'd9 || rf_wr !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_commit: got a3=%0d wr=%b expected 9/1", rf_a3, rf_wr); end
    compared++; if (resv_ready !== 1'b0 || hazard2 !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_still_full: got rr=%b hz=%b expected 0/1", resv_ready, hazard2); end
    resv_valid = 1'b0;
  endtask

  task automatic test_r0();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hDEAD_BEEF;
    resv_valid = 1'b1; resv_addr = 5'd0; rd_a2 = 5'd0;
    #1;
    compared++; if (req0_ready !== 1'b1 || resv_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL r0_ready: got req=%b resv=%b expected 1/1", req0_ready, resv_ready); end
    step();
    req0_valid = 1'b0;
    #1;
    compared++; if (rf_wr !== 1'b0 || rf_a3 !== 5'd0 || rf_wd !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL r0_commit: got wr=%b a3=%0d wd=%h expected 0/0/deadbeef", rf_wr, rf_a3, rf_wd); end
    step();
    compared++; if (hazard2 !== 1'b0) begin mismatched++; $display("[TB] FAIL r0_hazard: got %b expected 0", hazard2); end
    resv_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    resv_valid = 1'b1; resv_addr = 5'd4; rd_a1 = 5'd4; rd_a2 = 5'd9;
    step();
    resv_valid = 1'b0;
    #1;
    compared++; if (hazard1 !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reserved: got %b expected 1", hazard1); end
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'hCAFE;
    rst = 1'b0;
    step();
    compared++; if (rf_wr !== 1'b0 || rf_a3 !== 5'd0) begin mismatched++; $display("[TB] FAIL mid_rf: got wr=%b a3=%0d expected 0/0", rf_wr, rf_a3); end
    compared++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_hazard: got %b%b expected 00", hazard1, hazard2); end
    rst = 1'b1;
    req1_valid = 1'b0;
    step();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    resv_valid = 1'b0; resv_addr = '0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rd_a1 = '0; rd_a2 = '0;
    test_reset();
    test_contested();
    test_rr_ptr();
    test_scoreboard();
    test_saturation();
    test_r0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. It shares the register file's single write port between two producers: req0 is the ALU result path and req1 is the load/memory path. It grants one write per cycle with round-robin fairness and presents a registered write (write enable, address, data) to the register file. It also keeps a per-register pending-write count so the issue stage can detect read-after-write hazards on the two read addresses.

## Interface
Parameters:
- DW, 32, data width of write data
- AW, 5, register address width (2^AW registers)
- CW, 2, pending-counter width per register (max 2^CW−1 outstanding writes)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- resv_valid  in  1  issue stage reserves a future write to resv_addr
- resv_addr  in  AW  destination register being reserved
- resv_ready  out  1  reservation can be accepted (comb.)
- req0_valid / req1_valid  in  1  producer has a write-back
- req0_addr / req1_addr  in  AW  destination register
- req0_data / req1_data  in  DW  write data
- req0_ready / req1_ready  out  1  grant, combinational from valids and RR pointer
- rf_wr  out  1  register-file write enable (registered)
- rf_a3  out  AW  register-file write address (registered)
- rf_wd  out  DW  register-file write data (registered)
- rd_a1, rd_a2  in  AW  issue-stage source addresses
- hazard1, hazard2  out  1  pending write exists for rd_a1 / rd_a2 (comb.)

## Operation
- **Handshake:** a transfer occurs when reqN_valid && reqN_ready. Valid must hold with stable addr/data until the transfer occurs.
- **Arbitration:** at most one ready per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by rr_ptr is granted, and rr_ptr flips to the other requester.
  - rr_ptr changes only on a contested grant.
- **Commit:** on a transfer, rf_a3/rf_wd load the granted addr/data. rf_wr loads 1, unless the address is 0, in which case rf_wr loads 0.
  - A write to r0 is still accepted (ready=1) and consumed.
- **Pending counters:** cnt[r], width CW, one per register. cnt[0] is always 0.
  - A reservation (resv_valid && resv_ready, resv_addr≠0) increments cnt[resv_addr].
  - A transfer with addr≠0 decrements cnt[addr].
  - Reservation and transfer to the same register in the same cycle: cnt unchanged.
- **resv_ready:** 0 when cnt[resv_addr] == 2^CW−1 and no transfer to resv_addr occurs this cycle; otherwise 1. Always 1 for resv_addr=0.
- **Hazard outputs:** hazardN = (cnt[rd_aN] ≠ 0). This is always 0 for address 0.
- **Underflow:** a transfer to a register with cnt=0 is a protocol error. cnt stays 0 (saturating) and the write still commits.

## Timing
- **Reset** (rst=0 at a rising edge):
  - rf_wr=0, rf_a3=0, rf_wd=0.
  - All cnt=0, rr_ptr=0 (req0 favoured).
  - Combinational outputs follow the reset state: hazard1=hazard2=0, resv_ready=1.
  - reqN_ready is still driven combinationally during reset, but transfers in reset cycles are discarded.
- **Reset mid-operation:** pending counts and any in-flight registered write are dropped. rf_wr is 0 in the cycle after the reset edge.
- **Write-back latency:** 1 cycle. A handshake at edge k gives rf_wr/rf_a3/rf_wd valid from edge k through edge k+1.
  - The register file samples on the falling edge inside that cycle.
- **Hazard clear:** cnt decrements at the same edge k. hazard deasserts in the cycle rf_wr is high, and the register file read data is valid after that cycle's falling edge.
- **Throughput:** rf_wr=0 in any cycle following one with no transfer. Back-to-back transfers give one write per cycle.
- **Simultaneous events:** reserve + commit + read of the same register in one cycle leaves cnt unchanged, and hazard reflects the pre-edge count.

## Structure
- **Package rf_wb_pkg:**
  - DW, AW, CW defaults.
  - CNT_MAX = 2^CW−1.
  - Typedef wb_req_t {addr, data}.
  - R0 constant.
- **Sub-module rr_arb2:** 2-way round-robin arbiter (valids in → grants out, rr_ptr register). Instantiated once.
- **Top level:** counters, registered commit stage, hazard lookup.

## Test plan
- **Reset:** assert rst=0 for 2 cycles with req0 valid (addr 3, data 0xAAAA_0001) → rf_wr=0, all hazards 0, resv_ready=1; after release, the write appears at rf_a3=3 one cycle later.
- **Contested grants:** both requesters valid (req0 r5/0x11, req1 r6/0x22) for 2 cycles, rr_ptr=0 → grant order req0 then req1; rf_a3 sequence 5, 6; rf_wr high 2 consecutive cycles.
- **Scoreboard flow:** reserve r7 twice → hazard1 (rd_a1=7) =1. Commit r7 once → still 1. Commit again → 0 in the cycle rf_wr=1 for the second write.
- **Saturation:** reserve r9 three times → resv_ready=0 for r9. Then reserve r9 in the same cycle req1 commits r9 → resv_ready=1 and cnt stays 3.
- **Register 0:** req0 write to r0 with 0xDEAD_BEEF → req0_ready=1, rf_wr=0 next cycle; reserving r0 leaves hazard=0 for rd_a2=0.
- **Reset mid-operation:** reserve r4, hold req1 valid, assert rst=0 → next cycle rf_wr=0 and hazard for r4 =0.
